// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if (plus mem_arbiter_pkg)
// Description : Shared memory-port types and the cache/memory bus bundle
//               presented to mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;
endpackage

interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    MEM_COMMAND icache_command;
    ADDR        icache_addr;
    MEM_COMMAND dcache_command;
    ADDR        dcache_addr;
    MEM_BLOCK   dcache_data;
    MEM_TAG     mem2proc_transaction_tag;
    MEM_BLOCK   mem2proc_data;
    MEM_TAG     mem2proc_data_tag;

    MEM_COMMAND proc2mem_command;
    ADDR        proc2mem_addr;
    MEM_BLOCK   proc2mem_data;
    MEM_TAG     Imem2proc_transaction_tag;
    MEM_BLOCK   Imem2proc_data;
    MEM_TAG     Imem2proc_data_tag;
    MEM_TAG     Dmem2proc_transaction_tag;
    MEM_BLOCK   Dmem2proc_data;
    MEM_TAG     Dmem2proc_data_tag;
    logic       dcache_request;
    logic       tag_error;

    // Arbiter side
    modport slave (
        input  icache_command, icache_addr,
        input  dcache_command, dcache_addr, dcache_data,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output Imem2proc_transaction_tag, Imem2proc_data, Imem2proc_data_tag,
        output Dmem2proc_transaction_tag, Dmem2proc_data, Dmem2proc_data_tag,
        output dcache_request, tag_error
    );

    // Caches + memory side
    modport master (
        output icache_command, icache_addr,
        output dcache_command, dcache_addr, dcache_data,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  Imem2proc_transaction_tag, Imem2proc_data, Imem2proc_data_tag,
        input  Dmem2proc_transaction_tag, Dmem2proc_data, Dmem2proc_data_tag,
        input  dcache_request, tag_error
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single memory port between icache and dcache,
//               tracks load-tag ownership and routes responses to the owner.
//               Optional statistics counters: define MEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  wire logic   clock,
    input  wire logic   reset,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_igrant,
    output logic [31:0] stat_dgrant,
    output logic [31:0] stat_conflict,
    output logic [31:0] stat_drop
`endif
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0]          r_starve_cnt;
    logic [NUM_TAGS-1:0] r_valid;
    logic [NUM_TAGS-1:0] r_owner_d;      // 1: dcache owns the tag
    logic                r_tag_error;
    logic                r_first_after_rst;

    logic   w_ireq, w_dreq, w_igrant, w_dgrant;
    logic   w_accept, w_alloc, w_alloc_valid, w_alloc_in_range, w_alloc_collision;
    logic   w_rsp_present, w_rsp_hit, w_rsp_owner_d, w_drop;
    MEM_TAG w_alloc_tag, w_rsp_tag;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_ireq   = (bus.icache_command != MEM_NONE);
    assign w_dreq   = (bus.dcache_command != MEM_NONE);
    assign w_igrant = w_ireq && (!w_dreq || (r_starve_cnt == c_starve_limit));
    assign w_dgrant = w_dreq && !w_igrant;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (w_ireq && !w_igrant) begin
            if (r_starve_cnt != c_starve_limit) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    always_comb begin
        bus.proc2mem_command          = MEM_NONE;
        bus.proc2mem_addr             = '0;
        bus.proc2mem_data             = '0;
        bus.Imem2proc_transaction_tag = '0;
        bus.Dmem2proc_transaction_tag = '0;
        if (w_dgrant) begin
            bus.proc2mem_command          = bus.dcache_command;
            bus.proc2mem_addr             = bus.dcache_addr;
            bus.proc2mem_data             = bus.dcache_data;
            bus.Dmem2proc_transaction_tag = bus.mem2proc_transaction_tag;
        end else if (w_igrant) begin
            bus.proc2mem_command          = bus.icache_command;
            bus.proc2mem_addr             = bus.icache_addr;
            bus.Imem2proc_transaction_tag = bus.mem2proc_transaction_tag;
        end
    end

    assign bus.dcache_request = w_dgrant;

    // ------------------------------------------------------------------
    // Tag ownership table
    // ------------------------------------------------------------------
    assign w_alloc_tag      = bus.mem2proc_transaction_tag;
    assign w_rsp_tag        = bus.mem2proc_data_tag;
    assign w_accept         = (w_igrant || w_dgrant) && (w_alloc_tag != '0);
    assign w_alloc_in_range = (int'(w_alloc_tag) < NUM_TAGS);
    assign w_alloc          = w_accept && w_alloc_in_range
                              && (bus.proc2mem_command == MEM_LOAD);

    always_comb begin
        w_alloc_valid = 1'b0;
        w_rsp_hit     = 1'b0;
        w_rsp_owner_d = 1'b0;
        for (int i = 1; i < NUM_TAGS; i++) begin
            if (int'(w_alloc_tag) == i) begin
                w_alloc_valid = r_valid[i];
            end
            if (int'(w_rsp_tag) == i) begin
                w_rsp_hit     = r_valid[i];
                w_rsp_owner_d = r_owner_d[i];
            end
        end
    end

    assign w_rsp_present = (w_rsp_tag != '0);
    assign w_drop        = w_rsp_present && !w_rsp_hit;
    // Reusing a tag that is being returned in the same cycle is legitimate
    assign w_alloc_collision = w_alloc && w_alloc_valid
                               && !(w_rsp_hit && (w_rsp_tag == w_alloc_tag));

    for (genvar i = 0; i < NUM_TAGS; i++) begin : g_tag
        always_ff @(posedge clock) begin
            if (reset) begin
                r_valid[i]   <= 1'b0;
                r_owner_d[i] <= 1'b0;
            end else if (w_alloc && (int'(w_alloc_tag) == i)) begin
                r_valid[i]   <= 1'b1;
                r_owner_d[i] <= w_dgrant;
            end else if (w_rsp_hit && (int'(w_rsp_tag) == i)) begin
                r_valid[i]   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    always_comb begin
        bus.Imem2proc_data     = '0;
        bus.Imem2proc_data_tag = '0;
        bus.Dmem2proc_data     = '0;
        bus.Dmem2proc_data_tag = '0;
        if (w_rsp_hit) begin
            if (w_rsp_owner_d) begin
                bus.Dmem2proc_data     = bus.mem2proc_data;
                bus.Dmem2proc_data_tag = w_rsp_tag;
            end else begin
                bus.Imem2proc_data     = bus.mem2proc_data;
                bus.Imem2proc_data_tag = w_rsp_tag;
            end
        end
    end

    // Stale responses from before reset land in the first cycle out of
    // reset and are dropped silently rather than flagged.
    always_ff @(posedge clock) begin
        r_first_after_rst <= reset;
        if (reset) begin
            r_tag_error <= 1'b0;
        end else if ((w_drop && !r_first_after_rst) || w_alloc_collision) begin
            r_tag_error <= 1'b1;
        end
    end

    assign bus.tag_error = r_tag_error;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_stat_igrant, r_stat_dgrant, r_stat_conflict, r_stat_drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_igrant   <= '0;
            r_stat_dgrant   <= '0;
            r_stat_conflict <= '0;
            r_stat_drop     <= '0;
        end else begin
            if (w_accept && w_igrant && (r_stat_igrant != '1)) begin
                r_stat_igrant <= r_stat_igrant + 32'd1;
            end
            if (w_accept && w_dgrant && (r_stat_dgrant != '1)) begin
                r_stat_dgrant <= r_stat_dgrant + 32'd1;
            end
            if (w_ireq && w_dreq && (r_stat_conflict != '1)) begin
                r_stat_conflict <= r_stat_conflict + 32'd1;
            end
            if (w_drop && (r_stat_drop != '1)) begin
                r_stat_drop <= r_stat_drop + 32'd1;
            end
        end
    end

    assign stat_igrant   = r_stat_igrant;
    assign stat_dgrant   = r_stat_dgrant;
    assign stat_conflict = r_stat_conflict;
    assign stat_drop     = r_stat_drop;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_igrant, stat_dgrant, stat_conflict, stat_drop;
`endif

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .NUM_TAGS     (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_igrant   (stat_igrant),
        .stat_dgrant   (stat_dgrant),
        .stat_conflict (stat_conflict),
        .stat_drop     (stat_drop)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.icache_command           = MEM_NONE;
        bus.icache_addr              = '0;
        bus.dcache_command           = MEM_NONE;
        bus.dcache_addr              = '0;
        bus.dcache_data              = '0;
        bus.mem2proc_transaction_tag = '0;
        bus.mem2proc_data            = '0;
        bus.mem2proc_data_tag        = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_cmd", 64'(bus.proc2mem_command), 64'(MEM_NONE));
        chk("rst_tag_error", 64'(bus.tag_error), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_addr", 64'(bus.proc2mem_addr), 64'd0);
        chk("post_rst_dreq", 64'(bus.dcache_request), 64'd0);

        // Icache-only load, tag 3
        bus.icache_command           = MEM_LOAD;
        bus.icache_addr              = 32'h100;
        bus.mem2proc_transaction_tag = 4'd3;
        #1;
        chk("i_load_cmd", 64'(bus.proc2mem_command), 64'(MEM_LOAD));
        chk("i_load_addr", 64'(bus.proc2mem_addr), 64'h100);
        chk("i_load_data", 64'(bus.proc2mem_data), 64'd0);
        chk("i_load_itag", 64'(bus.Imem2proc_transaction_tag), 64'd3);
        chk("i_load_dtag", 64'(bus.Dmem2proc_transaction_tag), 64'd0);
        chk("i_load_dreq", 64'(bus.dcache_request), 64'd0);
        tick();
        idle();
        tick();
        bus.mem2proc_data_tag = 4'd3;
        bus.mem2proc_data     = 64'hDEAD;
        #1;
        chk("i_rsp_data", 64'(bus.Imem2proc_data), 64'hDEAD);
        chk("i_rsp_tag", 64'(bus.Imem2proc_data_tag), 64'd3);
        chk("i_rsp_d_data", 64'(bus.Dmem2proc_data), 64'd0);
        chk("i_rsp_d_tag", 64'(bus.Dmem2proc_data_tag), 64'd0);
        tick();
        idle();
        #1;
        chk("i_rsp_err", 64'(bus.tag_error), 64'd0);

        // Starvation: dcache stores vs icache loads every cycle
        for (int i = 1; i <= 10; i++) begin
            bus.icache_command           = MEM_LOAD;
            bus.icache_addr              = 32'h200;
            bus.dcache_command           = MEM_STORE;
            bus.dcache_addr              = 32'h300;
            bus.dcache_data              = 64'h1234_5678;
            bus.mem2proc_transaction_tag = (i <= 5) ? 4'd12 : 4'd13;
            #1;
            if ((i % 5) != 0) begin
                chk("starve_dreq", 64'(bus.dcache_request), 64'd1);
                chk("starve_daddr", 64'(bus.proc2mem_addr), 64'h300);
                chk("starve_ddata", 64'(bus.proc2mem_data), 64'h1234_5678);
                chk("starve_itag0", 64'(bus.Imem2proc_transaction_tag), 64'd0);
            end else begin
                chk("starve_ireq", 64'(bus.dcache_request), 64'd0);
                chk("starve_iaddr", 64'(bus.proc2mem_addr), 64'h200);
                chk("starve_idata", 64'(bus.proc2mem_data), 64'd0);
                chk("starve_dtag0", 64'(bus.Dmem2proc_transaction_tag), 64'd0);
            end
            tick();
        end
        idle();
        #1;
        chk("starve_err", 64'(bus.tag_error), 64'd0);

        // Out-of-order returns: dcache tag 5, icache tag 6
        bus.dcache_command           = MEM_LOAD;
        bus.dcache_addr              = 32'h400;
        bus.mem2proc_transaction_tag = 4'd5;
        #1;
        chk("ooo_dtag", 64'(bus.Dmem2proc_transaction_tag), 64'd5);
        chk("ooo_dtag_i0", 64'(bus.Imem2proc_transaction_tag), 64'd0);
        tick();
        idle();
        bus.icache_command           = MEM_LOAD;
        bus.icache_addr              = 32'h500;
        bus.mem2proc_transaction_tag = 4'd6;
        #1;
        chk("ooo_itag", 64'(bus.Imem2proc_transaction_tag), 64'd6);
        tick();
        idle();
        bus.mem2proc_data_tag = 4'd6;
        bus.mem2proc_data     = 64'h6666;
        #1;
        chk("ooo6_idata", 64'(bus.Imem2proc_data), 64'h6666);
        chk("ooo6_itag", 64'(bus.Imem2proc_data_tag), 64'd6);
        chk("ooo6_ddata", 64'(bus.Dmem2proc_data), 64'd0);
        chk("ooo6_dtag", 64'(bus.Dmem2proc_data_tag), 64'd0);
        tick();
        bus.mem2proc_data_tag = 4'd5;
        bus.mem2proc_data     = 64'h5555;
        #1;
        chk("ooo5_ddata", 64'(bus.Dmem2proc_data), 64'h5555);
        chk("ooo5_dtag", 64'(bus.Dmem2proc_data_tag), 64'd5);
        chk("ooo5_itag", 64'(bus.Imem2proc_data_tag), 64'd0);
        tick();
        idle();
        #1;
        chk("ooo_err", 64'(bus.tag_error), 64'd0);

        // Rejected icache load resets the starvation counter
        for (int i = 0; i < 2; i++) begin
            bus.icache_command = MEM_LOAD;
            bus.dcache_command = MEM_STORE;
            #1;
            chk("rej_pre_dreq", 64'(bus.dcache_request), 64'd1);
            tick();
        end
        idle();
        bus.icache_command = MEM_LOAD;
        bus.icache_addr    = 32'h600;
        #1;
        chk("rej_itag", 64'(bus.Imem2proc_transaction_tag), 64'd0);
        chk("rej_cmd", 64'(bus.proc2mem_command), 64'(MEM_LOAD));
        tick();
        for (int i = 1; i <= 5; i++) begin
            bus.icache_command = MEM_LOAD;
            bus.dcache_command = MEM_STORE;
            #1;
            chk("rej_post_dreq", 64'(bus.dcache_request), (i == 5) ? 64'd0 : 64'd1);
            tick();
        end
        idle();
        #1;
        chk("rej_err", 64'(bus.tag_error), 64'd0);

        // Store response is dropped and flagged
        bus.dcache_command           = MEM_STORE;
        bus.dcache_addr              = 32'h700;
        bus.dcache_data              = 64'hCAFE;
        bus.mem2proc_transaction_tag = 4'd2;
        #1;
        chk("st_dtag", 64'(bus.Dmem2proc_transaction_tag), 64'd2);
        tick();
        idle();
        bus.mem2proc_data_tag = 4'd2;
        bus.mem2proc_data     = 64'hBEEF;
        #1;
        chk("st_rsp_ddata", 64'(bus.Dmem2proc_data), 64'd0);
        chk("st_rsp_dtag", 64'(bus.Dmem2proc_data_tag), 64'd0);
        chk("st_rsp_itag", 64'(bus.Imem2proc_data_tag), 64'd0);
        tick();
        idle();
        #1;
        chk("st_err_set", 64'(bus.tag_error), 64'd1);
        tick();
        chk("st_err_sticky", 64'(bus.tag_error), 64'd1);

        // Load tag 7, reset, stale response after reset
        bus.icache_command           = MEM_LOAD;
        bus.mem2proc_transaction_tag = 4'd7;
        #1;
        chk("rr_itag", 64'(bus.Imem2proc_transaction_tag), 64'd7);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem2proc_data_tag = 4'd7;
        bus.mem2proc_data     = 64'h7777;
        #1;
        chk("rr_idata", 64'(bus.Imem2proc_data), 64'd0);
        chk("rr_itag_rsp", 64'(bus.Imem2proc_data_tag), 64'd0);
        chk("rr_dtag_rsp", 64'(bus.Dmem2proc_data_tag), 64'd0);
        chk("rr_err_first", 64'(bus.tag_error), 64'd0);
        tick();
        idle();
        #1;
        chk("rr_err_after", 64'(bus.tag_error), 64'd0);

        // Same-cycle free and re-allocate of tag 4
        bus.icache_command           = MEM_LOAD;
        bus.mem2proc_transaction_tag = 4'd4;
        tick();
        idle();
        bus.dcache_command           = MEM_LOAD;
        bus.mem2proc_transaction_tag = 4'd4;
        bus.mem2proc_data_tag        = 4'd4;
        bus.mem2proc_data            = 64'h4444;
        #1;
        chk("sc_idata", 64'(bus.Imem2proc_data), 64'h4444);
        chk("sc_dtag", 64'(bus.Dmem2proc_transaction_tag), 64'd4);
        tick();
        idle();
        bus.mem2proc_data_tag = 4'd4;
        bus.mem2proc_data     = 64'h4545;
        #1;
        chk("sc_ddata", 64'(bus.Dmem2proc_data), 64'h4545);
        chk("sc_err", 64'(bus.tag_error), 64'd0);
        tick();
        idle();

        // Allocate an already-valid tag: error, new owner wins
        bus.icache_command           = MEM_LOAD;
        bus.mem2proc_transaction_tag = 4'd9;
        tick();
        idle();
        bus.dcache_command           = MEM_LOAD;
        bus.mem2proc_transaction_tag = 4'd9;
        tick();
        idle();
        bus.mem2proc_data_tag = 4'd9;
        bus.mem2proc_data     = 64'h9999;
        #1;
        chk("dup_err", 64'(bus.tag_error), 64'd1);
        chk("dup_ddata", 64'(bus.Dmem2proc_data), 64'h9999);
        chk("dup_idata", 64'(bus.Imem2proc_data), 64'd0);
        tick();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
